// File: rtl/stream_demux_buf.sv
// stream_demux_buf: registered 1-to-N valid/ready demultiplexer with a one-entry buffer per channel.
// Optional: define STREAM_DEMUX_STATS_EN to add per-channel saturating accept counters (stat_sel/stat_cnt).
module stream_demux_buf #(
    parameter int WIDTH = 2,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    input  logic [WIDTH-1:0]      in_data,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [N_CH*WIDTH-1:0] out_data,
    output logic                  sel_err
`ifdef STREAM_DEMUX_STATS_EN
    ,
    input  logic [SEL_W-1:0]      stat_sel,
    output logic [CNT_W-1:0]      stat_cnt
`endif
);
    localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(N_CH);

    if (N_CH < 2 || N_CH > 16 || (2**SEL_W) < N_CH || CNT_W < 1 || WIDTH < 1) begin : g_param_chk
        $error("stream_demux_buf: invalid parameter combination");
    end

    logic [N_CH-1:0]       hit;
    logic [N_CH-1:0]       free;
    logic [N_CH-1:0]       load;
    logic [N_CH-1:0]       vld_nxt;
    logic [N_CH-1:0]       vld_p1;
    logic [N_CH*WIDTH-1:0] data_p1;
    logic                  oor;
    logic                  acc;
    logic                  err_p1;

    // A draining buffer counts as free, so in_ready never looks at in_valid.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit[i] = (in_sel == SEL_W'(i));
        end
        free = ~vld_p1 | out_ready;
        oor  = !in_bcast && ({1'b0, in_sel} >= NCH_L);
        if (rst)           in_ready = 1'b0;
        else if (in_bcast) in_ready = &free;
        else if (oor)      in_ready = 1'b1;
        else               in_ready = |(hit & free);
        acc  = in_valid && in_ready;
        load = '0;
        if (acc && !oor) begin
            load = in_bcast ? '1 : hit;
        end
    end

    always_comb begin
        vld_nxt = load | (vld_p1 & ~out_ready);
    end

    // Stage p1: output buffers and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= '0;
            data_p1 <= '0;
            err_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_nxt;
            err_p1 <= acc && oor;
            for (int i = 0; i < N_CH; i++) begin
                if (load[i]) data_p1[i*WIDTH +: WIDTH] <= in_data;
            end
        end
    end

    always_comb begin
        out_valid = vld_p1;
        out_data  = data_p1;
        sel_err   = err_p1;
    end

`ifdef STREAM_DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_p1 [N_CH];
    logic [CNT_W-1:0] stat_p2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage p1: counters; stage p2: registered read-out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cnt_p1[i] <= '0;
            stat_p2 <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (load[i]) cnt_p1[i] <= sat_inc(cnt_p1[i]);
            end
            stat_p2 <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (stat_sel == SEL_W'(i)) stat_p2 <= cnt_p1[i];
            end
        end
    end

    assign stat_cnt = stat_p2;
`endif

endmodule

// File: tb/tb_stream_demux_buf.sv
// Bench for stream_demux_buf: directed scenarios plus randomized traffic against a queue-based scoreboard.
module tb_stream_demux_buf;
    localparam int W  = 2;
    localparam int N  = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_bcast = 1'b0;
    logic [SW-1:0]  in_sel = '0;
    logic [W-1:0]   in_data = '0;
    logic [N-1:0]   out_ready = '0;
    logic           in_ready;
    logic           sel_err;
    logic [N-1:0]   out_valid;
    logic [N*W-1:0] out_data;

    logic           v3 = 1'b0;
    logic [1:0]     sel3 = '0;
    logic [1:0]     d3 = '0;
    logic [2:0]     ordy3 = '0;
    logic           rdy3;
    logic           err3;
    logic [2:0]     ov3;
    logic [5:0]     od3;

`ifdef STREAM_DEMUX_STATS_EN
    logic [SW-1:0]  stat_sel = '0;
    logic [1:0]     stat_cnt;
    logic [1:0]     stat_cnt3;
    int             cnt_m [N];
    logic [1:0]     exp_stat = '0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    stream_demux_buf #(.WIDTH(W), .N_CH(N), .SEL_W(SW), .CNT_W(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sel_err(sel_err)
`ifdef STREAM_DEMUX_STATS_EN
        , .stat_sel(stat_sel), .stat_cnt(stat_cnt)
`endif
    );

    stream_demux_buf #(.WIDTH(2), .N_CH(3), .SEL_W(2), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_sel(sel3),
        .in_bcast(1'b0), .in_data(d3), .out_valid(ov3), .out_ready(ordy3),
        .out_data(od3), .sel_err(err3)
`ifdef STREAM_DEMUX_STATS_EN
        , .stat_sel(2'd0), .stat_cnt(stat_cnt3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of outstanding beats per channel plus the last value loaded.
    logic [W-1:0] q [N][$];
    logic [W-1:0] last [N];
    logic         exp_err = 1'b0;

    function automatic logic model_ready();
        logic r;
        if (rst) return 1'b0;
        if (in_bcast) begin
            r = 1'b1;
            for (int i = 0; i < N; i++) r &= (q[i].size() == 0) || out_ready[i];
            return r;
        end
        if (int'(in_sel) >= N) return 1'b1;
        return (q[in_sel].size() == 0) || out_ready[in_sel];
    endfunction

    always @(posedge clk) begin : model
        logic r;
        logic a;
        r = model_ready();
`ifdef STREAM_DEMUX_STATS_EN
        exp_stat = rst ? 2'd0 : 2'(cnt_m[stat_sel]);
`endif
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                q[i].delete();
                last[i] = '0;
`ifdef STREAM_DEMUX_STATS_EN
                cnt_m[i] = 0;
`endif
            end
            exp_err = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() != 0 && out_ready[i]) void'(q[i].pop_front());
            end
            a = in_valid && r;
            exp_err = a && !in_bcast && (int'(in_sel) >= N);
            for (int i = 0; i < N; i++) begin
                if (a && (in_bcast || int'(in_sel) == i)) begin
                    q[i].push_back(in_data);
                    last[i] = in_data;
`ifdef STREAM_DEMUX_STATS_EN
                    if (cnt_m[i] < 3) cnt_m[i] = cnt_m[i] + 1;
`endif
                end
            end
        end
    end

    logic          pv = 1'b0;
    logic          pr = 1'b1;
    logic [SW-1:0] ps = '0;
    logic          pb = 1'b0;
    logic [W-1:0]  pd = '0;

    always @(negedge clk) begin : monitor
        chk("in_ready", in_ready, model_ready());
        chk("sel_err", sel_err, exp_err);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("out_valid[%0d]", i), out_valid[i], q[i].size() != 0);
            chk($sformatf("out_data_last[%0d]", i), out_data[i*W +: W], last[i]);
            if (q[i].size() != 0) chk($sformatf("sb_data[%0d]", i), out_data[i*W +: W], q[i][0]);
        end
`ifdef STREAM_DEMUX_STATS_EN
        chk("stat_cnt", stat_cnt, exp_stat);
`endif
        if (pv && !pr) chk("producer_hold", {in_sel, in_bcast, in_data}, {ps, pb, pd});
        pv = in_valid; pr = in_ready; ps = in_sel; pb = in_bcast; pd = in_data;
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] kk;
        logic       stall;
        // Reset held two cycles with a pending beat
        in_valid = 1'b1; in_sel = 2'd2; in_data = 2'b01;
        repeat (2) begin
            smp();
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_out_valid", out_valid, 4'b0000);
            chk("rst_out_data", out_data, 8'h00);
        end
        #1 rst = 1'b0;
        #1 chk("t1_ready", in_ready, 1'b1);
        cyc(); in_valid = 1'b0;
        smp();
        chk("t1_out_valid", out_valid, 4'b0100);
        chk("t1_ch2", out_data[5:4], 2'b01);

        // Back-to-back unicast to ch1
        cyc(); out_ready = 4'b1111; in_valid = 1'b1; in_sel = 2'd1;
        for (int k = 1; k <= 3; k++) begin
            kk = 2'(k);
            in_data = kk;
            smp();
            chk("t2_ready", in_ready, 1'b1);
            if (k > 1) begin
                chk("t2_ch1", out_data[3:2], kk - 2'd1);
                chk("t2_vld1", out_valid[1], 1'b1);
            end
            cyc();
        end
        in_valid = 1'b0;
        smp();
        chk("t2_ch1_last", out_data[3:2], 2'b11);
        chk("t2_vld1_last", out_valid[1], 1'b1);

        // Stalled ch3 blocks only its own beat
        cyc(); out_ready = 4'b0111; in_valid = 1'b1; in_sel = 2'd3; in_data = 2'b01;
        smp(); chk("t3_ready_empty", in_ready, 1'b1);
        cyc(); in_data = 2'b11;
        smp(); chk("t3_ready_stall", in_ready, 1'b0);
        cyc();
        smp(); chk("t3_ready_stall2", in_ready, 1'b0);
        chk("t3_ch3_old", out_data[7:6], 2'b01);
        cyc(); out_ready = 4'b1111;
        smp(); chk("t3_ready_release", in_ready, 1'b1);
        cyc(); in_sel = 2'd0; in_data = 2'b10;
        smp();
        chk("t3_ch3_new", out_data[7:6], 2'b11);
        chk("t3_vld3", out_valid[3], 1'b1);
        chk("t3_ready_ch0", in_ready, 1'b1);
        cyc(); in_valid = 1'b0;
        smp();
        chk("t3_ch0", out_data[1:0], 2'b10);
        chk("t3_vld0", out_valid[0], 1'b1);

        // Broadcast is all-or-nothing
        cyc(); out_ready = 4'b1011; in_valid = 1'b1; in_sel = 2'd2; in_data = 2'b11;
        smp(); chk("t4_ready_uni", in_ready, 1'b1);
        cyc(); in_bcast = 1'b1; in_data = 2'b10;
        smp(); chk("t4_ready_bc_stall", in_ready, 1'b0);
        cyc();
        smp();
        chk("t4_ready_bc_stall2", in_ready, 1'b0);
        chk("t4_vld_none", out_valid, 4'b0100);
        chk("t4_data_none", out_data, 8'hFE);
        cyc(); out_ready = 4'b0100;
        smp(); chk("t4_ready_bc", in_ready, 1'b1);
        cyc(); in_valid = 1'b0; in_bcast = 1'b0;
        smp();
        chk("t4_vld_all", out_valid, 4'b1111);
        chk("t4_data_all", out_data, 8'hAA);

        // Mid-stream reset with full buffers
        cyc(); out_ready = 4'b0000;
        smp(); chk("t5_full", out_valid[1:0], 2'b11);
        cyc(); rst = 1'b1;
        smp(); chk("t5_ready_rst", in_ready, 1'b0);
        cyc(); rst = 1'b0;
        smp();
        chk("t5_vld", out_valid, 4'b0000);
        chk("t5_data", out_data, 8'h00);

        // Out-of-range select on a 3-channel instance
        cyc(); v3 = 1'b1; sel3 = 2'd0; d3 = 2'b10;
        cyc(); sel3 = 2'd3; d3 = 2'b01;
        smp();
        chk("t6_ready", rdy3, 1'b1);
        chk("t6_err_pre", err3, 1'b0);
        chk("t6_vld_pre", ov3, 3'b001);
        cyc(); v3 = 1'b0;
        smp();
        chk("t6_err", err3, 1'b1);
        chk("t6_vld", ov3, 3'b001);
        chk("t6_data", od3, 6'b000010);
        cyc();
        smp();
        chk("t6_err_once", err3, 1'b0);
        chk("t6_vld_post", ov3, 3'b001);

`ifdef STREAM_DEMUX_STATS_EN
        // Counter saturation on ch2
        cyc(); out_ready = 4'b1111; stat_sel = 2'd2; in_valid = 1'b1; in_sel = 2'd2; in_data = 2'b01;
        repeat (5) cyc();
        in_valid = 1'b0;
        cyc();
        smp(); chk("t7_stat_sat", stat_cnt, 2'b11);
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        smp(); chk("t7_stat_rst", stat_cnt, 2'b00);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            smp();
            stall = in_valid && !in_ready;
            cyc();
            rst = ($urandom_range(0, 199) == 0);
            out_ready = 4'($urandom);
`ifdef STREAM_DEMUX_STATS_EN
            stat_sel = 2'($urandom);
`endif
            if (!stall) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_bcast = ($urandom_range(0, 6) == 0);
                in_sel   = 2'($urandom);
                in_data  = 2'($urandom);
            end
        end
        rst = 1'b0;
        smp();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
